// File: rtl/rca_ctrl_pkg.sv
// rtl/rca_ctrl_pkg.sv - shared types for the byte-serial ripple-carry add sequencer
package rca_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_8_bit.sv
// rtl/rca_8_bit.sv - 8-bit ripple-carry adder
module rca_8_bit
  import rca_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              c_in,
  output logic [BYTE_W-1:0] sum,
  output logic              c_out
);

  always_comb begin
    logic cy;
    cy  = c_in;
    sum = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c_out = cy;
  end

endmodule

// File: rtl/rca_byte_serial_ctrl.sv
// rtl/rca_byte_serial_ctrl.sv - adds two NUM_BYTES-byte operands one byte per clock
// through a single shared rca_8_bit, LSB byte first, with a start/busy/done handshake.
module rca_byte_serial_ctrl
  import rca_ctrl_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_BYTES*BYTE_W-1:0] a,
  input  logic [NUM_BYTES*BYTE_W-1:0] b,
  input  logic                       c_in,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_BYTES*BYTE_W-1:0] sum,
  output logic                       c_out
);

  localparam int W     = NUM_BYTES * BYTE_W;
  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [W-1:0]      a_reg, b_reg, acc, acc_merged;
  logic [BYTE_W-1:0] a_byte, b_byte, sum8;
  logic              c_out8;
  logic              accept, last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (idx == LAST_IDX);
  assign busy   = (state == RUN);

  assign a_byte = a_reg[idx*BYTE_W +: BYTE_W];
  assign b_byte = b_reg[idx*BYTE_W +: BYTE_W];

  rca_8_bit u_rca (
    .a     (a_byte),
    .b     (b_byte),
    .c_in  (carry),
    .sum   (sum8),
    .c_out (c_out8)
  );

  // Final byte is merged here so sum is loaded complete in the same edge as the last add.
  always_comb begin
    acc_merged = acc;
    acc_merged[idx*BYTE_W +: BYTE_W] = sum8;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= (state_next == DONE);
      if (accept) begin
        a_reg <= a;
        b_reg <= b;
        carry <= c_in;
        idx   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_merged;
        carry <= c_out8;
        if (last) begin
          sum   <= acc_merged;
          c_out <= c_out8;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule
